// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Handles the imem req/ack handshake, a one-entry stall skid buffer, and branch redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic [31:0] target;
    logic [31:0] addr_inc;

    assign target   = {branch_target_i[31:2], 2'b00};
    assign addr_inc = req_addr_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        hold_buf_d = hold_buf_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StFetch;
                    req_addr_d = fetch_pc_q;
                end
            end
            StFetch: begin
                if (flush_i) begin
                    instr_d    = NOP_INSTR;
                    valid_d    = 1'b0;
                    fetch_pc_d = target;
                    // Without an ack the old request must complete before redirecting.
                    if (imem_ack_i) begin
                        req_addr_d = target;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (imem_ack_i) begin
                    if (!stall_i) begin
                        pc_d       = req_addr_q;
                        instr_d    = imem_data_i;
                        valid_d    = 1'b1;
                        req_addr_d = addr_inc;
                        fetch_pc_d = addr_inc;
                    end else begin
                        hold_buf_d = imem_data_i;
                        state_d    = StHold;
                    end
                end else if (!stall_i) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            StHold: begin
                if (flush_i) begin
                    instr_d    = NOP_INSTR;
                    valid_d    = 1'b0;
                    hold_buf_d = '0;
                    fetch_pc_d = target;
                    req_addr_d = target;
                    state_d    = StFetch;
                end else if (!stall_i) begin
                    pc_d       = req_addr_q;
                    instr_d    = hold_buf_q;
                    valid_d    = 1'b1;
                    req_addr_d = addr_inc;
                    fetch_pc_d = addr_inc;
                    state_d    = StFetch;
                end
            end
            StDrain: begin
                if (flush_i) begin
                    fetch_pc_d = target;
                end
                if (imem_ack_i) begin
                    req_addr_d = fetch_pc_d;
                    state_d    = StFetch;
                end
                if (flush_i || !stall_i) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_buf_q <= '0;
            pc_q       <= '0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            hold_buf_q <= hold_buf_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req_o  = (state_q == StFetch) || (state_q == StDrain);
    assign imem_addr_o = req_addr_q;
    assign pc_o        = pc_q;
    assign instr_o     = instr_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset/wrap sequences, and a
// scoreboarded random-stall stream against a wait-state memory model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start, stall, flush, ack;
    logic [31:0] tgt, data;
    logic        req;
    logic [31:0] addr, pc, instr;
    logic        valid;

    logic        start1;
    logic        ack1;
    logic        req1;
    logic [31:0] addr1, pc1, instr1;
    logic        valid1;
    logic [31:0] zero32;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
        .branch_target_i(tgt), .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack),
        .imem_data_i(data), .pc_o(pc), .instr_o(instr), .valid_o(valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .stall_i(1'b0), .flush_i(1'b0),
        .branch_target_i(zero32), .imem_req_o(req1), .imem_addr_o(addr1),
        .imem_ack_i(ack1), .imem_data_i(addr1), .pc_o(pc1), .instr_o(instr1),
        .valid_o(valid1)
    );

    function automatic logic [31:0] md(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        start, stall, flush;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] data;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc, exp_instr;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic sl, input logic fl,
                                input logic [31:0] t, input logic a, input logic [31:0] d,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.start = st; v.stall = sl; v.flush = fl; v.tgt = t; v.ack = a; v.data = d;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_instr = ei;
        return v;
    endfunction

    task automatic reset_and_check(input string tag);
        @(negedge clk);
        rst = 1'b0;
        start = 0; stall = 0; flush = 0; ack = 0; tgt = 0; data = BAD; start1 = 0;
        #1;
        chk({tag, "_req"}, {31'd0, req}, 32'd0);
        chk({tag, "_addr"}, addr, 32'h0);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_instr"}, instr, NOP);
        chk({tag, "_wrap_addr"}, addr1, 32'hFFFF_FFFC);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t        tbl[22];
    logic [31:0] exp_q[$];
    logic [31:0] last_pc;
    logic [31:0] cur_addr;
    logic [31:0] e;
    logic        busy;
    int          wcnt;
    int          popped;

    task automatic pop_check();
        if (valid && pc != last_pc) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pc", pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", pc, e);
                chk("sb_instr", instr, md(e));
                popped++;
            end
            last_pc = pc;
        end
    endtask

    initial begin
        zero32 = 32'h0;
        ack1   = 1'b1;
        start = 0; stall = 0; flush = 0; ack = 0; tgt = 0; data = BAD; start1 = 0;

        tbl[0]  = mk(1, 0, 0, 0,      0, BAD,       0, 32'h000, 0, 32'h000, NOP);
        tbl[1]  = mk(0, 0, 0, 0,      1, md(0),     1, 32'h000, 1, 32'h000, md(0));
        tbl[2]  = mk(0, 0, 0, 0,      1, md(4),     1, 32'h004, 1, 32'h004, md(4));
        tbl[3]  = mk(0, 0, 0, 0,      0, BAD,       1, 32'h008, 0, 32'h004, NOP);
        tbl[4]  = mk(0, 0, 0, 0,      0, BAD,       1, 32'h008, 0, 32'h004, NOP);
        tbl[5]  = mk(0, 0, 0, 0,      1, md(8),     1, 32'h008, 1, 32'h008, md(8));
        tbl[6]  = mk(0, 1, 0, 0,      1, md(12),    1, 32'h00C, 1, 32'h008, md(8));
        tbl[7]  = mk(0, 1, 0, 0,      1, BAD,       0, 32'h00C, 1, 32'h008, md(8));
        tbl[8]  = mk(0, 1, 0, 0,      0, BAD,       0, 32'h00C, 1, 32'h008, md(8));
        tbl[9]  = mk(0, 0, 0, 0,      0, BAD,       0, 32'h00C, 1, 32'h00C, md(12));
        tbl[10] = mk(1, 0, 0, 0,      1, md(16),    1, 32'h010, 1, 32'h010, md(16));
        tbl[11] = mk(0, 0, 1, 32'h103, 0, BAD,      1, 32'h014, 0, 32'h010, NOP);
        tbl[12] = mk(0, 0, 0, 0,      0, BAD,       1, 32'h014, 0, 32'h010, NOP);
        tbl[13] = mk(0, 0, 0, 0,      1, BAD,       1, 32'h014, 0, 32'h010, NOP);
        tbl[14] = mk(0, 0, 0, 0,      1, md(32'h100), 1, 32'h100, 1, 32'h100, md(32'h100));
        tbl[15] = mk(0, 0, 1, 32'h200, 1, BAD,      1, 32'h104, 0, 32'h100, NOP);
        tbl[16] = mk(0, 0, 0, 0,      1, md(32'h200), 1, 32'h200, 1, 32'h200, md(32'h200));
        tbl[17] = mk(0, 1, 0, 0,      1, md(32'h204), 1, 32'h204, 1, 32'h200, md(32'h200));
        tbl[18] = mk(0, 1, 1, 32'h301, 0, BAD,      0, 32'h204, 0, 32'h200, NOP);
        tbl[19] = mk(0, 0, 0, 0,      1, md(32'h300), 1, 32'h300, 1, 32'h300, md(32'h300));
        tbl[20] = mk(0, 1, 0, 0,      0, BAD,       1, 32'h304, 1, 32'h300, md(32'h300));
        tbl[21] = mk(0, 0, 0, 0,      1, md(32'h304), 1, 32'h304, 1, 32'h304, md(32'h304));

        reset_and_check("rst0");

        // Wrap-around instance: zero-wait memory returning its address as data.
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        #1;
        chk("wrap_req", {31'd0, req1}, 32'd1);
        chk("wrap_addr0", addr1, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        chk("wrap_pc0", pc1, 32'hFFFF_FFFC);
        chk("wrap_valid0", {31'd0, valid1}, 32'd1);
        @(negedge clk); #1;
        chk("wrap_addr1", addr1, 32'h0);
        @(posedge clk); #1;
        chk("wrap_pc1", pc1, 32'h0);
        chk("wrap_instr1", instr1, 32'h0);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            start = tbl[i].start; stall = tbl[i].stall; flush = tbl[i].flush;
            tgt = tbl[i].tgt; ack = tbl[i].ack; data = tbl[i].data;
            #1;
            chk($sformatf("vec%0d_req", i), {31'd0, req}, {31'd0, tbl[i].exp_req});
            chk($sformatf("vec%0d_addr", i), addr, tbl[i].exp_addr);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].exp_valid});
            chk($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
            chk($sformatf("vec%0d_instr", i), instr, tbl[i].exp_instr);
        end

        // Reset while a request is outstanding: outputs clear without a clock edge.
        @(negedge clk);
        start = 0; stall = 0; flush = 0; ack = 0; data = BAD;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_req", {31'd0, req}, 32'd0);
        chk("midrst_addr", addr, 32'h0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_instr", instr, NOP);
        @(negedge clk);
        rst = 1'b1;

        // Scoreboarded stream with random stalls and 0..2 wait cycles.
        last_pc = 32'hFFFF_FFFF;
        busy = 1'b0;
        wcnt = 0;
        popped = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        for (int w = 0; w < 3; w++) begin
            for (int n = 0; n < 80; n++) begin
                @(negedge clk);
                start = 1'b0;
                stall = ($urandom_range(0, 3) == 0);
                ack = 1'b0;
                data = BAD;
                if (req) begin
                    if (busy) chk("sb_addr_stable", addr, cur_addr);
                    else begin
                        busy = 1'b1;
                        cur_addr = addr;
                    end
                    if (wcnt >= w) begin
                        ack = 1'b1;
                        data = md(addr);
                        exp_q.push_back(addr);
                        wcnt = 0;
                        busy = 1'b0;
                    end else begin
                        wcnt++;
                    end
                end
                @(posedge clk); #1;
                pop_check();
            end
        end
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            stall = 1'b0;
            ack = 1'b0;
            @(posedge clk); #1;
            pop_check();
        end
        chk("sb_leftover", exp_q.size(), 32'd0);
        chk("sb_progress", {31'd0, (popped > 40)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
